// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM states and peripheral region geometry for the APB master
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
  localparam logic [31:0] REGION_SIZE = 32'h0000_1000;
  localparam int REGION_BITS = $clog2(REGION_SIZE);
endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: maps a byte address onto a one-hot slave select inside the peripheral window
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int          NSLV      = 4,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic [31:REGION_BITS] addr,
  output logic [NSLV-1:0]       sel,
  output logic                  mapped
);
  localparam int HI = REGION_BITS + $clog2(NSLV);
  // window match on the bits above the slave index, then one-hot the index
  always_comb begin
    mapped = addr[31:HI] == BASE_ADDR[31:HI];
    sel    = mapped ? {{(NSLV-1){1'b0}}, 1'b1} << addr[HI-1:REGION_BITS] : '0;
  end
endmodule

// File: rtl/apb_master.sv
// apb_master: single-outstanding core-to-APB bridge with address decode and access timeout
module apb_master
  import apb_pkg::*;
#(
  parameter int          NSLV      = 4,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          TIMEOUT   = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iReq,
  input  logic             iWrEn,
  input  logic [31:0]      iAddr,
  input  logic [31:0]      iWrData,
  input  logic [3:0]       iStrb,
  output logic [31:0]      oRdData,
  output logic             oReady,
  output logic             oErr,
  output logic [NSLV-1:0]  oPSel,
  output logic             oPEnable,
  output logic             oPWrite,
  output logic [31:0]      oPAddr,
  output logic [31:0]      oPWData,
  output logic [3:0]       oPStrb,
  input  logic [NSLV*32-1:0] iPRData,
  input  logic [NSLV-1:0]  iPReady,
  input  logic [NSLV-1:0]  iPSlvErr
);
  localparam int CW = $clog2(TIMEOUT);
  apb_state_e state, state_n;
  logic            wr_q;
  logic [31:0]     addr_q, wdata_q, rdata_s;
  logic [3:0]      strb_q;
  logic [NSLV-1:0] sel_q, sel_d;
  logic [CW-1:0]   cnt;
  logic            mapped, accept, rdy, done, tmo;
  apb_addr_decode #(.NSLV(NSLV), .BASE_ADDR(BASE_ADDR)) u_dec (
    .addr  (iAddr[31:REGION_BITS]),
    .sel   (sel_d),
    .mapped(mapped)
  );
  // selected-slave response mux and transfer events
  always_comb begin
    rdata_s = '0;
    for (int i = 0; i < NSLV; i++) rdata_s |= iPRData[32*i +: 32] & {32{sel_q[i]}};
    accept = state == IDLE && iReq && !oReady;
    rdy    = |(iPReady & sel_q);
    done   = state == ACCESS && rdy;
    tmo    = state == ACCESS && !rdy && cnt == CW'(TIMEOUT - 1);
  end
  // state register
  always_ff @(posedge iClk or negedge iRst)
    if (!iRst) state <= IDLE;
    else state <= state_n;
  // next state and APB request outputs
  always_comb begin
    state_n  = state == IDLE   ? (accept && mapped ? SETUP : IDLE) :
               state == SETUP  ? ACCESS :
               (done || tmo)   ? IDLE : ACCESS;
    oPSel    = state == IDLE ? '0 : sel_q;
    oPEnable = state == ACCESS;
    oPWrite  = wr_q;
    oPAddr   = addr_q;
    oPWData  = wdata_q;
    oPStrb   = wr_q ? strb_q : 4'b0000;
  end
  // request latch, access-cycle counter and registered completion
  always_ff @(posedge iClk or negedge iRst)
    if (!iRst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      sel_q   <= '0;
      cnt     <= '0;
      oReady  <= 1'b0;
      oErr    <= 1'b0;
      oRdData <= '0;
    end else begin
      if (accept) begin
        wr_q    <= iWrEn;
        addr_q  <= iAddr;
        wdata_q <= iWrData;
        strb_q  <= iStrb;
        sel_q   <= sel_d;
      end
      cnt     <= state == ACCESS ? cnt + CW'(1) : '0;
      oReady  <= done || tmo || (accept && !mapped);
      oErr    <= done ? |(iPSlvErr & sel_q) : tmo || (accept && !mapped);
      oRdData <= done && !wr_q ? rdata_s : '0;
    end
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter NSLV, default 4, meaning number of APB slaves; power of two, 2..8.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h1000_0000, meaning base of peripheral window; each slave owns a 4 KB region.
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning ACCESS-phase cycles allowed before error completion; minimum 2.
REQ-004 SHALL have port iClk  in  1  the single clock; all flops on its rising edge.
REQ-005 SHALL have port iRst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port iReq  in  1  core data request; held high until oReady is seen.
REQ-007 SHALL have port iWrEn  in  1  1 = write, 0 = read.
REQ-008 SHALL have port iAddr  in  32  byte address.
REQ-009 SHALL have port iWrData  in  32  write data.
REQ-010 SHALL have port iStrb  in  4  byte-lane write strobes.
REQ-011 SHALL have port oRdData  out  32  read data, valid while oReady=1.
REQ-012 SHALL have port oReady  out  1  one-cycle completion pulse.
REQ-013 SHALL have port oErr  out  1  error flag, valid while oReady=1.
REQ-014 SHALL have port oPSel  out  NSLV  one-hot slave select.
REQ-015 SHALL have ports oPEnable (out, 1), oPWrite (out, 1), oPAddr (out, 32), oPWData (out, 32), oPStrb (out, 4): APB request signals.
REQ-016 SHALL have ports iPRData (in, NSLV*32, slave k at bits [32k+31:32k]), iPReady (in, NSLV), iPSlvErr (in, NSLV).

Function
REQ-017 SHALL implement states IDLE, SETUP, ACCESS.
REQ-018 In IDLE with iReq=1 and oReady=0, SHALL latch iWrEn, iAddr, iWrData, iStrb at the rising edge; while latched, iAddr/iWrData SHALL NOT affect APB outputs.
REQ-019 SHALL treat an address as mapped when iAddr[31:12+log2(NSLV)] equals the same bits of BASE_ADDR; slave index = iAddr[12+log2(NSLV)-1:12].
REQ-020 On a mapped accept, SHALL go to SETUP: oPSel one-hot for the indexed slave, oPEnable=0, with oPAddr/oPWrite/oPWData/oPStrb from the latch.
REQ-021 SHALL move SETUP -> ACCESS unconditionally after one cycle, with oPEnable=1 and all other APB outputs unchanged.
REQ-022 In ACCESS, on the selected slave's iPReady=1, SHALL capture its iPRData (0 for writes) and iPSlvErr, go to IDLE, and drive oReady=1 for exactly the next cycle with captured oRdData/oErr.
REQ-023 SHALL count ACCESS cycles; when TIMEOUT cycles elapse with iPReady=0, SHALL go to IDLE and complete with oErr=1, oRdData=0.
REQ-024 On an unmapped accept, SHALL stay in IDLE, never assert oPSel, and pulse oReady=1 with oErr=1, oRdData=0 in the next cycle.
REQ-025 iPReady/iPRData/iPSlvErr of non-selected slaves SHALL be ignored.
REQ-026 oPSel and oPEnable SHALL be 0 in IDLE; oPStrb SHALL be driven 4'b0000 for reads.
REQ-027 Minimum mapped latency SHALL be 3 cycles (accept edge to oReady high).
REQ-028 iReq deasserted mid-transfer SHALL NOT abort the transfer; completion still pulses oReady.
REQ-029 Back-to-back requests SHALL be accepted in the first IDLE cycle in which oReady=0.

Reset
REQ-030 On iRst=0, SHALL asynchronously enter IDLE, clear the latch and timeout counter, and drive oReady=0, oErr=0, oRdData=0, oPSel=0, oPEnable=0, oPWrite=0, oPAddr=0, oPWData=0, oPStrb=0.
REQ-031 A reset during SETUP or ACCESS SHALL drop oPSel/oPEnable immediately and produce no oReady pulse.

Structure
REQ-032 SHALL place the state enum (IDLE, SETUP, ACCESS) and the 4 KB region-size constant in a shared package, apb_pkg.
REQ-033 Address decode SHALL be a combinational sub-module, apb_addr_decode (iAddr -> one-hot select, mapped flag).

Verification
REQ-034 Write 32'hDEAD_BEEF to 32'h1000_1004, strobe 4'hF, slave 1 iPReady=1 -> SETUP then ACCESS on oPSel=4'b0010, oPWData=32'hDEAD_BEEF; oReady after 3 cycles, oErr=0.
REQ-035 Read 32'h1000_3000, slave 3 holds iPReady=0 for 2 ACCESS cycles, returns 32'h1234_5678 -> oReady 5 cycles after accept with oRdData=32'h1234_5678.
REQ-036 Read 32'h2000_0000 (unmapped) -> oPSel stays 0; oReady next cycle with oErr=1, oRdData=0.
REQ-037 Read slave 2 with iPReady stuck at 0 -> after 16 ACCESS cycles oReady=1, oErr=1, oRdData=0, oPSel returns to 0.
REQ-038 Assert iRst=0 during ACCESS -> oPSel=0, oPEnable=0 immediately; no oReady; a new request is served normally after reset.
REQ-039 Slave 0 iPSlvErr=1 with iPReady=1, plus non-selected slave 1 iPReady=1 throughout -> completion only from slave 0, oErr=1.
